// File: rtl/dds_link_pkg.sv
// Shared types and constants for the DDS serial link blocks.
// Provides the scheduler state encoding, link word width and clock rate.
package dds_link_pkg;

   localparam int DDS_WORD_W = 12;
   localparam int CLK_HZ     = 10_000_000;

   typedef enum logic [2:0] {
      IDLE,
      HOLDOFF,
      ARB,
      SHIFT,
      GAP
   } state_t;

endpackage

// File: rtl/trig_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// Ports: clk, rst (async high), d (async level in), pulse (1-cycle out).
module trig_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse
);

   logic s1;
   logic s2;
   logic s2_d;

   // pulse rises on the third edge after d goes high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         s2_d  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         s1    <= d;
         s2    <= s1;
         s2_d  <= s2;
         pulse <= s2 & ~s2_d;
      end
   end

endmodule

// File: rtl/dds_word_scheduler.sv
// Triggered round-robin scheduler serialising two word sources to the DDS.
// Ports: clock/reset, trigger, req valid/data/ready, serial+dflag, status.
module dds_word_scheduler
   import dds_link_pkg::*;
#(
   parameter int WORD_W     = DDS_WORD_W,
   parameter int TRIG_DELAY = 10000,
   parameter int GAP_CYCLES = 4
) (
   input  logic              Ten_MHz_wire,
   input  logic              reset_in,
   input  logic              sending_trigger_in,
   input  logic [1:0]        req_valid,
   input  logic [WORD_W-1:0] req_data_0,
   input  logic [WORD_W-1:0] req_data_1,
   output logic [1:0]        req_ready,
   output logic              serial_data_out_1_bit,
   output logic              dflag,
   output logic              grant_id,
   output logic              busy,
   output logic              missed_trigger,
   output logic              overrun
);

   localparam int BW = $clog2(WORD_W + 1);
   localparam logic [15:0]   CNT_LAST = 16'(TRIG_DELAY - 1);
   localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);
   localparam logic [BW-1:0] IDX_END  = BW'(WORD_W);

   state_t            state;
   logic [15:0]       cnt;
   logic [BW-1:0]     bit_idx;
   logic [7:0]        gap_cnt;
   logic [WORD_W-1:0] shreg;
   logic              last_grant;
   logic              trig_edge;
   logic              g;
   logic [WORD_W-1:0] word;

   trig_sync_edge u_trig (
      .clk   (Ten_MHz_wire),
      .rst   (reset_in),
      .d     (sending_trigger_in),
      .pulse (trig_edge)
   );

   // on contention, the source not served last time wins
   always_comb begin
      g = 1'b0;
      if (req_valid == 2'b11)
         g = ~last_grant;
      else
         g = req_valid[1];
      word = g ? req_data_1 : req_data_0;
   end

   always_ff @(posedge Ten_MHz_wire or posedge reset_in) begin
      if (reset_in) begin
         state                 <= IDLE;
         cnt                   <= '0;
         bit_idx               <= '0;
         gap_cnt               <= '0;
         shreg                 <= '0;
         last_grant            <= 1'b1;
         req_ready             <= '0;
         serial_data_out_1_bit <= 1'b0;
         dflag                 <= 1'b0;
         grant_id              <= 1'b0;
         busy                  <= 1'b0;
         missed_trigger        <= 1'b0;
         overrun               <= 1'b0;
      end else begin
         req_ready      <= '0;
         missed_trigger <= 1'b0;
         overrun        <= trig_edge && (state != IDLE);
         unique case (state)
            IDLE: begin
               if (trig_edge) begin
                  state <= HOLDOFF;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            HOLDOFF: begin
               cnt <= cnt + 16'd1;
               if (cnt == CNT_LAST)
                  state <= ARB;
            end
            ARB: begin
               if (req_valid == 2'b00) begin
                  missed_trigger <= 1'b1;
                  busy           <= 1'b0;
                  state          <= IDLE;
               end else begin
                  req_ready             <= g ? 2'b10 : 2'b01;
                  shreg                 <= word >> 1;
                  serial_data_out_1_bit <= word[0];
                  dflag                 <= 1'b1;
                  grant_id              <= g;
                  last_grant            <= g;
                  bit_idx               <= BW'(1);
                  state                 <= SHIFT;
               end
            end
            SHIFT: begin
               if (bit_idx == IDX_END) begin
                  dflag                 <= 1'b0;
                  serial_data_out_1_bit <= 1'b0;
                  gap_cnt               <= '0;
                  if (GAP_CYCLES == 0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= GAP;
                  end
               end else begin
                  serial_data_out_1_bit <= shreg[0];
                  shreg                 <= shreg >> 1;
                  bit_idx               <= bit_idx + BW'(1);
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt + 8'd1;
               if (gap_cnt == GAP_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dds_word_scheduler.sv
// Scoreboard bench for dds_word_scheduler (TRIG_DELAY=8, GAP_CYCLES=4).
// Frames are rebuilt from serial/dflag and compared to queued words.
module tb_dds_word_scheduler;

   typedef struct {
      logic        gid;
      logic [11:0] word;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trig = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [11:0] req_data_0 = '0;
   logic [11:0] req_data_1 = '0;
   logic [1:0]  req_ready;
   logic        serial;
   logic        dflag;
   logic        grant_id;
   logic        busy;
   logic        missed;
   logic        ovr;

   int n_chk = 0;
   int n_pass = 0;
   int n_ovr = 0;
   int n_miss = 0;
   int n_frames = 0;
   int nbits = 0;
   logic [11:0] rx;
   logic        rx_gid;
   exp_t        exp_q[$];
   exp_t        e;

   dds_word_scheduler #(
      .WORD_W     (12),
      .TRIG_DELAY (8),
      .GAP_CYCLES (4)
   ) dut (
      .Ten_MHz_wire          (clk),
      .reset_in              (rst),
      .sending_trigger_in    (trig),
      .req_valid             (req_valid),
      .req_data_0            (req_data_0),
      .req_data_1            (req_data_1),
      .req_ready             (req_ready),
      .serial_data_out_1_bit (serial),
      .dflag                 (dflag),
      .grant_id              (grant_id),
      .busy                  (busy),
      .missed_trigger        (missed),
      .overrun               (ovr)
   );

   always #50 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // frame monitor: rebuild LSB-first word while dflag is high
   always @(negedge clk) begin
      if (rst) begin
         nbits = 0;
      end else begin
         if (ovr) n_ovr++;
         if (missed) n_miss++;
         if (dflag) begin
            if (nbits == 0) rx_gid = grant_id;
            rx = {serial, rx[11:1]};
            nbits++;
         end else if (nbits != 0) begin
            check("frame_len", nbits, 12);
            if (exp_q.size() == 0) begin
               check("sb_pop", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("frame_word", {20'h0, rx}, {20'h0, e.word});
               check("frame_gid", rx_gid, e.gid);
            end
            n_frames++;
            nbits = 0;
         end
      end
   end

   task automatic do_reset();
      trig = 1'b0;
      rst  = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   int rdy_first, rdy_cnt, busy_first, busy_cnt, late_busy;
   logic [1:0] rdy_val;
   int miss_first, f0, o0, m0, ov1, ov2;
   logic b12, b13;

   initial begin
      // reset state
      #20;
      check("rst_outs", {req_ready, serial, dflag, grant_id, busy, missed, ovr}, 0);
      do_reset();

      // basic frame with req_data change mid-shift
      req_valid = 2'b01;
      req_data_0 = 12'hA5C;
      req_data_1 = 12'h777;
      exp_q.push_back('{1'b0, 12'hA5C});
      rdy_first = 0; rdy_cnt = 0; busy_first = 0; busy_cnt = 0;
      rdy_val = '0;
      trig = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 3) trig = 1'b0;
         if (k == 15) req_data_0 = 12'h000;
         if (req_ready != 2'b00) begin
            rdy_cnt++;
            if (rdy_first == 0) begin
               rdy_first = k;
               rdy_val = req_ready;
            end
         end
         if (busy) begin
            busy_cnt++;
            if (busy_first == 0) busy_first = k;
         end
      end
      check("rdy_lat", rdy_first, 13);
      check("rdy_cnt", rdy_cnt, 1);
      check("rdy_val", rdy_val, 2'b01);
      check("busy_first", busy_first, 4);
      check("busy_len", busy_cnt, 25);
      check("gid_basic", grant_id, 0);

      // round robin, fresh pointer
      do_reset();
      req_valid = 2'b11;
      req_data_0 = 12'h001;
      req_data_1 = 12'h800;
      exp_q.push_back('{1'b0, 12'h001});
      exp_q.push_back('{1'b1, 12'h800});
      exp_q.push_back('{1'b0, 12'h001});
      for (int t = 0; t < 3; t++) begin
         trig = 1'b1;
         repeat (3) @(negedge clk);
         trig = 1'b0;
         repeat (37) @(negedge clk);
      end
      check("rr_last_gid", grant_id, 0);

      // missed trigger
      do_reset();
      req_valid = 2'b00;
      m0 = n_miss; f0 = n_frames; miss_first = 0;
      b12 = 1'b0; b13 = 1'b1;
      trig = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 3) trig = 1'b0;
         if (missed && miss_first == 0) miss_first = k;
         if (k == 12) b12 = busy;
         if (k == 13) b13 = busy;
      end
      check("miss_lat", miss_first, 13);
      check("miss_cnt", n_miss - m0, 1);
      check("miss_busy_arb", b12, 1);
      check("miss_busy_fall", b13, 0);
      check("miss_frames", n_frames - f0, 0);

      // overrun during SHIFT and during last GAP cycle
      do_reset();
      req_valid = 2'b01;
      req_data_0 = 12'h6B3;
      exp_q.push_back('{1'b0, 12'h6B3});
      o0 = n_ovr; f0 = n_frames; ov1 = 0; ov2 = 0;
      rdy_cnt = 0; busy_cnt = 0; late_busy = 0;
      trig = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (k == 3 || k == 18 || k == 28) trig = 1'b0;
         if (k == 15 || k == 25) trig = 1'b1;
         if (ovr) begin
            if (ov1 == 0) ov1 = k;
            else if (ov2 == 0) ov2 = k;
         end
         if (req_ready != 2'b00) rdy_cnt++;
         if (busy) busy_cnt++;
         if (busy && k >= 29) late_busy++;
      end
      check("ovr_cnt", n_ovr - o0, 2);
      check("ovr_shift_k", ov1, 19);
      check("ovr_gap_k", ov2, 29);
      check("ovr_rdy_cnt", rdy_cnt, 1);
      check("ovr_busy_len", busy_cnt, 25);
      check("ovr_no_refire", late_busy, 0);
      check("ovr_frames", n_frames - f0, 1);

      // asynchronous reset mid-frame
      do_reset();
      req_valid = 2'b01;
      req_data_0 = 12'hFFF;
      exp_q.push_back('{1'b0, 12'hFFF});
      trig = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         if (k == 3) trig = 1'b0;
      end
      check("mid_pre", {dflag, serial}, 2'b11);
      #5 rst = 1'b1;
      #1;
      check("mid_async", {dflag, serial, busy}, 3'b000);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      req_valid = 2'b11;
      req_data_0 = 12'h3C1;
      req_data_1 = 12'h0F0;
      exp_q.push_back('{1'b0, 12'h3C1});
      trig = 1'b1;
      repeat (3) @(negedge clk);
      trig = 1'b0;
      repeat (40) @(negedge clk);
      check("post_rst_gid", grant_id, 0);

      // held trigger: one frame, no overrun
      req_valid = 2'b10;
      req_data_1 = 12'h5A5;
      exp_q.push_back('{1'b1, 12'h5A5});
      o0 = n_ovr; f0 = n_frames;
      trig = 1'b1;
      repeat (200) @(negedge clk);
      trig = 1'b0;
      repeat (20) @(negedge clk);
      check("held_frames", n_frames - f0, 1);
      check("held_ovr", n_ovr - o0, 0);

      check("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
